// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the CPU step sequencer.
// State encoding and parameter defaults live here.
package cpu_ctrl_pkg;

    localparam int STEP_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BURST  = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef struct packed {
        logic run;
        logic step_rise;
        logic tick;
        logic halt;
    } ctl_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous operator input.
// Also produces a one-cycle pulse on the synced rising edge.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic ClockIn,
    input  logic Reset,
    input  logic AsyncIn,
    output logic Level,
    output logic Rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   level_d;

    // shift the async input through the chain, keep one delayed copy
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            chain   <= '0;
            level_d <= 1'b0;
        end else begin
            chain   <= {chain[SYNC_STAGES-2:0], AsyncIn};
            level_d <= chain[SYNC_STAGES-1];
        end
    end

    assign Level = chain[SYNC_STAGES-1];
    assign Rise  = chain[SYNC_STAGES-1] & ~level_d;

endmodule

// File: rtl/cpu_step_sequencer.sv
// Turns rate-divider ticks into CPU advance pulses under
// operator run/step/burst control and the CPU's own HALT.
module cpu_step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEP_W      = STEP_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              ClockIn,
    input  logic              Reset,
    input  logic              Tick,
    input  logic              RunReq,
    input  logic              StepReq,
    input  logic [STEP_W-1:0] BurstLen,
    input  logic              HaltIn,
    output logic              CpuEnable,
    output logic              Running,
    output logic              Halted,
    output logic [STEP_W-1:0] StepsDone
);

    ctl_t              ctl;
    logic              run_lvl;
    logic              run_rise_unused;
    logic              step_lvl_unused;
    logic              step_rise;
    state_t            state;
    state_t            state_nx;
    logic [STEP_W-1:0] rem;
    logic [STEP_W-1:0] rem_nx;
    logic              en_nx;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_run_sync (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .AsyncIn (RunReq),
        .Level   (run_lvl),
        .Rise    (run_rise_unused)
    );

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_step_sync (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .AsyncIn (StepReq),
        .Level   (step_lvl_unused),
        .Rise    (step_rise)
    );

    assign ctl = '{
        run:       run_lvl,
        step_rise: step_rise,
        tick:      Tick,
        halt:      HaltIn
    };

    // next state, burst count and enable; halt beats tick
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        en_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctl.run) begin
                    state_nx = RUN;
                end else if (ctl.step_rise) begin
                    state_nx = BURST;
                    rem_nx   = (BurstLen == '0) ? STEP_W'(1)
                                                : BurstLen;
                end
            end
            RUN: begin
                if (ctl.halt) begin
                    state_nx = HALTED;
                end else if (!ctl.run) begin
                    state_nx = IDLE;
                end else begin
                    en_nx = ctl.tick;
                end
            end
            BURST: begin
                if (ctl.halt) begin
                    state_nx = HALTED;
                    rem_nx   = '0;
                end else if (ctl.tick) begin
                    en_nx  = 1'b1;
                    rem_nx = rem - STEP_W'(1);
                    if (rem == STEP_W'(1)) begin
                        state_nx = IDLE;
                    end
                end
            end
            HALTED: begin
                if (!ctl.run && !ctl.halt) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            rem       <= '0;
            CpuEnable <= 1'b0;
            Running   <= 1'b0;
            Halted    <= 1'b0;
            StepsDone <= '0;
        end else begin
            state     <= state_nx;
            rem       <= rem_nx;
            CpuEnable <= en_nx;
            Running   <= (state_nx == RUN) || (state_nx == BURST);
            Halted    <= (state_nx == HALTED);
            if (en_nx) begin
                StepsDone <= StepsDone + STEP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Bench for cpu_step_sequencer: directed scenarios plus random
// traffic, compared each cycle against a behavioural model.
module tb_cpu_step_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_BURST = 2;
    localparam int M_HALT  = 3;

    logic       clk;
    logic       Reset;
    logic       Tick;
    logic       RunReq;
    logic       StepReq;
    logic [7:0] BurstLen;
    logic       HaltIn;

    logic       en8, run8, hlt8;
    logic [7:0] sd8;
    logic       en4, run4, hlt4;
    logic [3:0] sd4;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    bit prev_en = 0;
    bit last_tick = 0;

    int m_mode;
    int m_rem;
    int m_total;
    bit m_en;
    bit r_h[3];
    bit s_h[3];

    cpu_step_sequencer #(.STEP_W(8), .SYNC_STAGES(2)) dut8 (
        .ClockIn   (clk),
        .Reset     (Reset),
        .Tick      (Tick),
        .RunReq    (RunReq),
        .StepReq   (StepReq),
        .BurstLen  (BurstLen),
        .HaltIn    (HaltIn),
        .CpuEnable (en8),
        .Running   (run8),
        .Halted    (hlt8),
        .StepsDone (sd8)
    );

    cpu_step_sequencer #(.STEP_W(4), .SYNC_STAGES(2)) dut4 (
        .ClockIn   (clk),
        .Reset     (Reset),
        .Tick      (Tick),
        .RunReq    (RunReq),
        .StepReq   (StepReq),
        .BurstLen  (BurstLen[3:0]),
        .HaltIn    (HaltIn),
        .CpuEnable (en4),
        .Running   (run4),
        .Halted    (hlt4),
        .StepsDone (sd4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_rem   = 0;
        m_total = 0;
        m_en    = 0;
        for (int i = 0; i < 3; i++) begin
            r_h[i] = 0;
            s_h[i] = 0;
        end
    endtask

    // Operator inputs reach the control logic two edges late;
    // a step request is a synced 0->1 transition.
    task automatic model_edge();
        bit run;
        bit rise;
        bit en;
        run  = r_h[1];
        rise = s_h[1] && !s_h[2];
        en   = 0;
        case (m_mode)
            M_IDLE: begin
                if (run) m_mode = M_RUN;
                else if (rise) begin
                    m_mode = M_BURST;
                    m_rem  = (BurstLen == 0) ? 1 : int'(BurstLen);
                end
            end
            M_RUN: begin
                if (HaltIn) m_mode = M_HALT;
                else if (!run) m_mode = M_IDLE;
                else en = Tick;
            end
            M_BURST: begin
                if (HaltIn) begin
                    m_mode = M_HALT;
                    m_rem  = 0;
                end else if (Tick) begin
                    en    = 1;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_mode = M_IDLE;
                end
            end
            default: begin
                if (!run && !HaltIn) m_mode = M_IDLE;
            end
        endcase
        m_en = en;
        if (en) m_total++;
        r_h[2] = r_h[1];
        r_h[1] = r_h[0];
        r_h[0] = RunReq;
        s_h[2] = s_h[1];
        s_h[1] = s_h[0];
        s_h[0] = StepReq;
    endtask

    task automatic chk_outputs(input string ph);
        bit exp_run;
        exp_run = (m_mode == M_RUN) || (m_mode == M_BURST);
        chk({ph, " en8"},  32'(en8),  32'(m_en));
        chk({ph, " en4"},  32'(en4),  32'(m_en));
        chk({ph, " run8"}, 32'(run8), 32'(exp_run));
        chk({ph, " run4"}, 32'(run4), 32'(exp_run));
        chk({ph, " hlt8"}, 32'(hlt8), 32'(m_mode == M_HALT));
        chk({ph, " hlt4"}, 32'(hlt4), 32'(m_mode == M_HALT));
        chk({ph, " sd8"},  32'(sd8),  32'(m_total % 256));
        chk({ph, " sd4"},  32'(sd4),  32'(m_total % 16));
    endtask

    task automatic cyc(input string ph);
        @(posedge clk);
        if (!Reset) model_edge();
        @(negedge clk);
        chk_outputs(ph);
        chk({ph, " adjacent"}, 32'(prev_en & en8), 32'd0);
        prev_en = en8;
        if (en8) ecount++;
        last_tick = Tick;
        Tick = 1'b0;
    endtask

    task automatic idle(input int n, input string ph);
        repeat (n) cyc(ph);
    endtask

    task automatic ticks(input int n, input int gap, input string ph);
        repeat (n) begin
            Tick = 1'b1;
            cyc(ph);
            repeat (gap - 1) cyc(ph);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        idle(2, "reset");
        Reset = 1'b0;
    endtask

    task automatic step_pulse(input string ph);
        StepReq = 1'b1;
        idle(2, ph);
        StepReq = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        Tick     = 1'b0;
        RunReq   = 1'b0;
        StepReq  = 1'b0;
        BurstLen = 8'd0;
        HaltIn   = 1'b0;
        model_reset();

        do_reset();

        // no requests: ticks never reach the CPU
        ecount = 0;
        ticks(20, 5, "t1");
        chk("t1 enables", 32'(ecount), 32'd0);
        chk("t1 steps", 32'(sd8), 32'd0);

        // three-step burst
        BurstLen = 8'd3;
        step_pulse("t2");
        idle(3, "t2");
        ecount = 0;
        ticks(5, 3, "t2");
        chk("t2 enables", 32'(ecount), 32'd3);
        chk("t2 running", 32'(run8), 32'd0);
        chk("t2 steps", 32'(sd8), 32'd3);

        // zero length acts as one; a mid-burst edge is dropped
        BurstLen = 8'd0;
        step_pulse("t3a");
        idle(3, "t3a");
        ecount = 0;
        ticks(3, 3, "t3a");
        chk("t3 zero len", 32'(ecount), 32'd1);
        BurstLen = 8'd3;
        step_pulse("t3b");
        idle(3, "t3b");
        ecount = 0;
        ticks(1, 3, "t3b");
        BurstLen = 8'd4;
        step_pulse("t3b");
        idle(2, "t3b");
        ticks(6, 3, "t3b");
        chk("t3 mid edge", 32'(ecount), 32'd3);

        // free run, then halt coincident with a tick
        RunReq = 1'b1;
        idle(4, "t4");
        ecount = 0;
        ticks(10, 4, "t4");
        Tick   = 1'b1;
        HaltIn = 1'b1;
        idle(3, "t4");
        chk("t4 enables", 32'(ecount), 32'd10);
        chk("t4 halted", 32'(hlt8), 32'd1);
        RunReq = 1'b0;
        HaltIn = 1'b0;
        idle(4, "t4");
        chk("t4 released", 32'(hlt8), 32'd0);
        chk("t4 idle", 32'(run8), 32'd0);

        // 4-bit counter wraps after 16
        do_reset();
        RunReq = 1'b1;
        idle(4, "t5");
        ticks(17, 2, "t5");
        chk("t5 wrap4", 32'(sd4), 32'd1);
        chk("t5 count8", 32'(sd8), 32'd17);
        RunReq = 1'b0;
        idle(4, "t5");

        // async reset mid-burst
        BurstLen = 8'd5;
        step_pulse("t6");
        idle(3, "t6");
        ecount = 0;
        ticks(2, 3, "t6");
        chk("t6 issued", 32'(ecount), 32'd2);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk_outputs("t6 async");
        idle(2, "t6");
        Reset = 1'b0;
        ecount = 0;
        ticks(6, 3, "t6");
        chk("t6 after", 32'(ecount), 32'd0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) RunReq = ~RunReq;
            if ($urandom_range(0, 5) == 0) StepReq = ~StepReq;
            HaltIn   = ($urandom_range(0, 29) == 0);
            BurstLen = 8'($urandom_range(0, 15));
            Tick     = !last_tick && ($urandom_range(0, 2) == 0);
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
